// File: rtl/screg_bus_arbiter_if.sv
// Requester-side and register-bus-side signals of the SC register bus arbiter.
// The arbiter takes the master modport because it masters the register fabric.
interface screg_bus_arbiter_if #(
  parameter int NUM_MST = 2
);
  localparam int GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  logic [NUM_MST-1:0]    M_REQ;
  logic [NUM_MST-1:0]    M_WR;
  logic [NUM_MST*32-1:0] M_ADR;
  logic [NUM_MST*10-1:0] M_TYP;
  logic [NUM_MST*4-1:0]  M_WENB;
  logic [NUM_MST*32-1:0] M_WDAT;
  logic [NUM_MST-1:0]    M_ACK;
  logic [31:0]           M_RDAT;
  logic                  M_ERR;
  logic [GW-1:0]         M_GNT;

  logic [31:0] REG_WADR;
  logic [9:0]  REG_WTYP;
  logic [3:0]  REG_WENB;
  logic [31:0] REG_WDAT;
  logic        REG_WWAT;
  logic        REG_WERR;
  logic [31:0] REG_RADR;
  logic [9:0]  REG_RTYP;
  logic        REG_RENB;
  logic [31:0] REG_RDAT;
  logic        REG_RWAT;
  logic        REG_RERR;

  modport master (
    input  M_REQ, M_WR, M_ADR, M_TYP, M_WENB, M_WDAT,
    input  REG_WWAT, REG_WERR, REG_RDAT, REG_RWAT, REG_RERR,
    output M_ACK, M_RDAT, M_ERR, M_GNT,
    output REG_WADR, REG_WTYP, REG_WENB, REG_WDAT, REG_RADR, REG_RTYP, REG_RENB
  );

  modport slave (
    output M_REQ, M_WR, M_ADR, M_TYP, M_WENB, M_WDAT,
    output REG_WWAT, REG_WERR, REG_RDAT, REG_RWAT, REG_RERR,
    input  M_ACK, M_RDAT, M_ERR, M_GNT,
    input  REG_WADR, REG_WTYP, REG_WENB, REG_WDAT, REG_RADR, REG_RTYP, REG_RENB
  );
endinterface

// File: rtl/screg_bus_arbiter.sv
// Round-robin arbiter sharing one SC register bus between NUM_MST requesters,
// one single-beat access at a time, with wait handling and stall timeout.
module screg_bus_arbiter #(
  parameter int NUM_MST = 2,
  parameter int TMO_CYC = 256,
  parameter int TMO_W   = 9
) (
  input  logic                 CLK,
  input  logic                 RESET,
  screg_bus_arbiter_if.master  bus
);
  localparam int GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam logic [GW:0] NUM_W = (GW+1)'(NUM_MST);
  localparam logic [TMO_W-1:0] TMO_LAST = (TMO_CYC > 0) ? TMO_W'(TMO_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  logic [31:0] adr_a  [NUM_MST];
  logic [9:0]  typ_a  [NUM_MST];
  logic [3:0]  wenb_a [NUM_MST];
  logic [31:0] wdat_a [NUM_MST];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MST; gi++) begin : g_unpack
      assign adr_a[gi]  = bus.M_ADR[32*gi +: 32];
      assign typ_a[gi]  = bus.M_TYP[10*gi +: 10];
      assign wenb_a[gi] = bus.M_WENB[4*gi +: 4];
      assign wdat_a[gi] = bus.M_WDAT[32*gi +: 32];
    end
  endgenerate

  state_t             state_q, state_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [GW-1:0]      g_q, g_d;
  logic               wr_q, wr_d;
  logic [31:0]        adr_q, adr_d;
  logic [9:0]         typ_q, typ_d;
  logic [3:0]         wenb_q, wenb_d;
  logic [31:0]        wdat_q, wdat_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [NUM_MST-1:0] ack_q, ack_d;
  logic [31:0]        rdat_q, rdat_d;
  logic               err_q, err_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [31:0]        reg_wadr_q, reg_wadr_d;
  logic [9:0]         reg_wtyp_q, reg_wtyp_d;
  logic [3:0]         reg_wenb_q, reg_wenb_d;
  logic [31:0]        reg_wdat_q, reg_wdat_d;
  logic [31:0]        reg_radr_q, reg_radr_d;
  logic [9:0]         reg_rtyp_q, reg_rtyp_d;
  logic               reg_renb_q, reg_renb_d;

  logic          found;
  logic [GW-1:0] sel;
  logic [GW:0]   cand;
  logic          wait_sel;
  logic          in_access;

  // First requesting index strictly after the pointer, wrapping modulo NUM_MST.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_MST; k++) begin
      cand = {1'b0, ptr_q} + (GW+1)'(k);
      if (cand >= NUM_W) cand = cand - NUM_W;
      if (!found && bus.M_REQ[cand[GW-1:0]]) begin
        found = 1'b1;
        sel   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    g_d      = g_q;
    wr_d     = wr_q;
    adr_d    = adr_q;
    typ_d    = typ_q;
    wenb_d   = wenb_q;
    wdat_d   = wdat_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    rdat_d   = '0;
    err_d    = 1'b0;
    wait_sel = wr_q ? bus.REG_WWAT : bus.REG_RWAT;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          g_d    = sel;
          ptr_d  = sel;
          gnt_d  = sel;
          wr_d   = bus.M_WR[sel];
          adr_d  = adr_a[sel];
          typ_d  = typ_a[sel];
          wenb_d = wenb_a[sel];
          wdat_d = wdat_a[sel];
          cnt_d  = '0;
          // A write with no byte lanes has nothing to do on the bus.
          if (bus.M_WR[sel] && wenb_a[sel] == 4'h0) begin
            state_d    = RESP;
            ack_d[sel] = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!wait_sel) begin
          state_d     = RESP;
          ack_d[g_q]  = 1'b1;
          err_d       = wr_q ? bus.REG_WERR : bus.REG_RERR;
          rdat_d      = wr_q ? 32'h0 : bus.REG_RDAT;
        end else if (TMO_CYC != 0 && cnt_q == TMO_LAST) begin
          state_d    = RESP;
          ack_d[g_q] = 1'b1;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    in_access  = (state_d == ACCESS);
    reg_wadr_d = (in_access && wr_d)  ? adr_d  : 32'h0;
    reg_wtyp_d = (in_access && wr_d)  ? typ_d  : 10'h0;
    reg_wenb_d = (in_access && wr_d)  ? wenb_d : 4'h0;
    reg_wdat_d = (in_access && wr_d)  ? wdat_d : 32'h0;
    reg_radr_d = (in_access && !wr_d) ? adr_d  : 32'h0;
    reg_rtyp_d = (in_access && !wr_d) ? typ_d  : 10'h0;
    reg_renb_d = in_access && !wr_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      ptr_q      <= GW'(NUM_MST - 1);
      g_q        <= '0;
      wr_q       <= 1'b0;
      adr_q      <= '0;
      typ_q      <= '0;
      wenb_q     <= '0;
      wdat_q     <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      rdat_q     <= '0;
      err_q      <= 1'b0;
      gnt_q      <= '0;
      reg_wadr_q <= '0;
      reg_wtyp_q <= '0;
      reg_wenb_q <= '0;
      reg_wdat_q <= '0;
      reg_radr_q <= '0;
      reg_rtyp_q <= '0;
      reg_renb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      wr_q       <= wr_d;
      adr_q      <= adr_d;
      typ_q      <= typ_d;
      wenb_q     <= wenb_d;
      wdat_q     <= wdat_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rdat_q     <= rdat_d;
      err_q      <= err_d;
      gnt_q      <= gnt_d;
      reg_wadr_q <= reg_wadr_d;
      reg_wtyp_q <= reg_wtyp_d;
      reg_wenb_q <= reg_wenb_d;
      reg_wdat_q <= reg_wdat_d;
      reg_radr_q <= reg_radr_d;
      reg_rtyp_q <= reg_rtyp_d;
      reg_renb_q <= reg_renb_d;
    end
  end

  assign bus.M_ACK    = ack_q;
  assign bus.M_RDAT   = rdat_q;
  assign bus.M_ERR    = err_q;
  assign bus.M_GNT    = gnt_q;
  assign bus.REG_WADR = reg_wadr_q;
  assign bus.REG_WTYP = reg_wtyp_q;
  assign bus.REG_WENB = reg_wenb_q;
  assign bus.REG_WDAT = reg_wdat_q;
  assign bus.REG_RADR = reg_radr_q;
  assign bus.REG_RTYP = reg_rtyp_q;
  assign bus.REG_RENB = reg_renb_q;
endmodule

// File: tb/tb_screg_bus_arbiter.sv
// Scoreboard bench for screg_bus_arbiter: expected responses are queued at
// request time and matched against each M_ACK as it appears.
module tb_screg_bus_arbiter;
  localparam int NM = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  screg_bus_arbiter_if #(.NUM_MST(NM)) bus ();

  screg_bus_arbiter #(.NUM_MST(NM), .TMO_CYC(4), .TMO_W(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] rdat;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Register-fabric model: wait for the first wait_cfg cycles of each access.
  int          wait_cfg = 0;
  int          acc_cnt  = 0;
  logic        err_cfg  = 1'b0;
  logic [31:0] rdat_cfg = 32'h0;

  assign bus.REG_WWAT = (acc_cnt < wait_cfg);
  assign bus.REG_RWAT = (acc_cnt < wait_cfg);
  assign bus.REG_WERR = err_cfg;
  assign bus.REG_RERR = err_cfg;
  assign bus.REG_RDAT = rdat_cfg;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    acc_cnt <= (bus.REG_RENB || bus.REG_WENB != 4'h0) ? acc_cnt + 1 : 0;
  end

  int          renb_cnt = 0;
  int          wenb_cnt = 0;
  logic [31:0] last_radr = '0, last_wadr = '0, last_wdat = '0;
  logic [9:0]  last_rtyp = '0, last_wtyp = '0;
  logic [3:0]  last_wenb = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] typ_of(input int i);
    return 10'h155 ^ 10'(i);
  endfunction

  // Monitor: bus activity bookkeeping and scoreboard matching on every M_ACK.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.REG_RENB) begin
        renb_cnt++;
        last_radr = bus.REG_RADR;
        last_rtyp = bus.REG_RTYP;
      end
      if (bus.REG_WENB != 4'h0) begin
        wenb_cnt++;
        last_wadr = bus.REG_WADR;
        last_wtyp = bus.REG_WTYP;
        last_wdat = bus.REG_WDAT;
        last_wenb = bus.REG_WENB;
      end
      if (|bus.M_ACK) begin
        if (sb.size() == 0) begin
          check_eq("ack_unexpected", 64'(bus.M_ACK), 64'h0);
        end else begin
          e = sb.pop_front();
          $display("ack m=%0d rdat=%08h err=%0b cyc=%0d", e.idx, bus.M_RDAT, bus.M_ERR, cyc);
          check_eq("ack_vec", 64'(bus.M_ACK), 64'(1 << e.idx));
          check_eq("ack_rdat", 64'(bus.M_RDAT), 64'(e.rdat));
          check_eq("ack_err", 64'(bus.M_ERR), 64'(e.err));
          check_eq("ack_cyc", 64'(cyc), 64'(e.cyc));
          check_eq("ack_gnt", 64'(bus.M_GNT), 64'(e.idx));
        end
      end else if (bus.M_RDAT != 32'h0 || bus.M_ERR) begin
        check_eq("resp_outside_ack", {31'h0, bus.M_ERR, bus.M_RDAT}, 64'h0);
      end
    end
  end

  task automatic wait_ack(input int i, input bit drop, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.M_ACK[i] && n < budget);
    if (!bus.M_ACK[i]) check_eq("ack_wait", 64'(bus.M_ACK[i]), 64'h1);
    if (drop) begin
      @(posedge clk);
      #1 bus.M_REQ[i] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] adr,
                         input logic [3:0] wenb, input logic [31:0] wdat);
    bus.M_WR[i]            = wr;
    bus.M_ADR[32*i +: 32]  = adr;
    bus.M_TYP[10*i +: 10]  = typ_of(i);
    bus.M_WENB[4*i +: 4]   = wenb;
    bus.M_WDAT[32*i +: 32] = wdat;
    bus.M_REQ[i]           = 1'b1;
  endtask

  task automatic do_access(input int i, input logic wr, input logic [31:0] adr,
                           input logic [3:0] wenb, input logic [31:0] wdat,
                           input logic [31:0] e_rdat, input logic e_err, input int lat);
    exp_t e;
    @(posedge clk);
    #1;
    set_req(i, wr, adr, wenb, wdat);
    e = '{idx: i, rdat: e_rdat, err: e_err, cyc: cyc + lat};
    sb.push_back(e);
    wait_ack(i, 1'b1, lat + 10);
  endtask

  initial begin
    int r0, w0;
    exp_t e;
    bus.M_REQ  = '0;
    bus.M_WR   = '0;
    bus.M_ADR  = '0;
    bus.M_TYP  = '0;
    bus.M_WENB = '0;
    bus.M_WDAT = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ack", 64'(bus.M_ACK), 64'h0);
    check_eq("rst_gnt", 64'(bus.M_GNT), 64'h0);
    check_eq("rst_renb", 64'(bus.REG_RENB), 64'h0);
    check_eq("rst_wenb", 64'(bus.REG_WENB), 64'h0);
    check_eq("rst_radr", 64'(bus.REG_RADR), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single read, no wait
    rdat_cfg = 32'hA5A5_0001;
    r0 = renb_cnt;
    do_access(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hA5A5_0001, 1'b0, 2);
    check_eq("rd_renb_cycles", 64'(renb_cnt - r0), 64'd1);
    check_eq("rd_radr", 64'(last_radr), 64'h10);
    check_eq("rd_rtyp", 64'(last_rtyp), 64'(typ_of(0)));

    // Write with three wait cycles and a slave error
    wait_cfg = 3; err_cfg = 1'b1; rdat_cfg = 32'hDEAD_BEEF;
    w0 = wenb_cnt;
    do_access(1, 1'b1, 32'h200, 4'h3, 32'h1234_5678, 32'h0, 1'b1, 5);
    check_eq("wr_wenb_cycles", 64'(wenb_cnt - w0), 64'd4);
    check_eq("wr_wenb", 64'(last_wenb), 64'h3);
    check_eq("wr_wdat", 64'(last_wdat), 64'h1234_5678);
    check_eq("wr_wadr", 64'(last_wadr), 64'h200);
    check_eq("wr_wtyp", 64'(last_wtyp), 64'(typ_of(1)));

    // Round robin with both requests held
    wait_cfg = 0; err_cfg = 1'b0; rdat_cfg = 32'h0000_0BB0;
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 32'h40, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'h44, 4'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      e = '{idx: k % 2, rdat: 32'h0000_0BB0, err: 1'b0, cyc: cyc + 2 + 3 * k};
      sb.push_back(e);
    end
    for (int k = 0; k < 6; k++) wait_ack(k % 2, k >= 4, 20);

    // Timeout: read wait stuck high
    wait_cfg = 100; rdat_cfg = 32'h7777_7777;
    r0 = renb_cnt;
    do_access(0, 1'b0, 32'h80, 4'h0, 32'h0, 32'h0, 1'b1, 5);
    check_eq("tmo_renb_cycles", 64'(renb_cnt - r0), 64'd4);
    wait_cfg = 0; rdat_cfg = 32'h0000_1234;
    do_access(1, 1'b0, 32'h84, 4'h0, 32'h0, 32'h0000_1234, 1'b0, 2);

    // Zero-enable write never reaches the bus
    err_cfg = 1'b1;
    w0 = wenb_cnt;
    do_access(0, 1'b1, 32'h90, 4'h0, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
    check_eq("zwr_wenb_cycles", 64'(wenb_cnt - w0), 64'd0);
    err_cfg = 1'b0;

    // Reset in the middle of a stalled write, then a simultaneous 0/1 request
    wait_cfg = 50;
    @(posedge clk);
    #1 set_req(0, 1'b1, 32'hA0, 4'hF, 32'h5555_AAAA);
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_wenb_pre", 64'(bus.REG_WENB), 64'hF);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_wenb_post", 64'(bus.REG_WENB), 64'h0);
    check_eq("mid_wadr_post", 64'(bus.REG_WADR), 64'h0);
    check_eq("mid_ack_post", 64'(bus.M_ACK), 64'h0);
    rst = 1'b0;
    wait_cfg = 0; rdat_cfg = 32'h0000_00C3;
    bus.M_REQ = '0;
    set_req(0, 1'b0, 32'hB0, 4'h0, 32'h0);
    set_req(1, 1'b0, 32'hB4, 4'h0, 32'h0);
    e = '{idx: 0, rdat: 32'h0000_00C3, err: 1'b0, cyc: cyc + 2};
    sb.push_back(e);
    e = '{idx: 1, rdat: 32'h0000_00C3, err: 1'b0, cyc: cyc + 5};
    sb.push_back(e);
    wait_ack(0, 1'b1, 20);
    wait_ack(1, 1'b1, 20);

    repeat (3) @(posedge clk);
    check_eq("sb_drained", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/screg_bus_arbiter.md
Name: screg_bus_arbiter

Overview:
- Shares one SC register bus (sc_regbus_t field set) between NUM_MST requesters with round-robin arbitration.
- Sequences each access as a single-beat read or write, honours the slave wait signals (wwat/rwat) and returns data and error to the granted requester.
- Aborts accesses that stall too long.
- Sits between requesters (CPU bridge, debug port, DMA) and the register decode fabric of a module.

Parameters:
- NUM_MST, 2, number of requesters (1..8)
- TMO_CYC, 256, maximum ACCESS cycles with wait asserted before abort; 0 disables timeout
- TMO_W, 9, width of the timeout counter; must satisfy 2**TMO_W > TMO_CYC

Ports:
- CLK  in  1  clock
- RESET  in  1  reset; one clock, synchronous, active-high
- M_REQ  in  NUM_MST  per-requester access request; held until M_ACK
- M_WR  in  NUM_MST  1 = write, 0 = read
- M_ADR  in  NUM_MST*32  byte address, requester i at [32*i+:32]
- M_TYP  in  NUM_MST*10  access type, copied to wtyp/rtyp
- M_WENB  in  NUM_MST*4  write byte enables
- M_WDAT  in  NUM_MST*32  write data
- M_ACK  out  NUM_MST  one-cycle completion pulse to the granted requester
- M_RDAT  out  32  read data, valid when any M_ACK is high; 0 for writes
- M_ERR  out  1  error, valid when any M_ACK is high
- M_GNT  out  $clog2(NUM_MST) (min 1)  index of the current or last grant
- REG_WADR/REG_WTYP/REG_WENB/REG_WDAT  out  32/10/4/32  bus write fields
- REG_WWAT/REG_WERR  in  1/1  write wait and write error
- REG_RADR/REG_RTYP/REG_RENB  out  32/10/1  bus read fields
- REG_RDAT  in  32  read data
- REG_RWAT/REG_RERR  in  1/1  read wait and read error

Behaviour:
- Reset: state IDLE; all outputs 0; RR pointer = NUM_MST-1, so requester 0 has priority on the first arbitration.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any M_REQ is high, select the first requester searching upward from pointer+1 (modulo NUM_MST).
  - Latch index g, WR, ADR, TYP, WENB, WDAT; update pointer = g; go to ACCESS.
  - Exception: a write with WENB == 0 goes directly to RESP with ERR = 0 and no bus activity.
- ACCESS, write:
  - Drive REG_WADR/WTYP/WDAT and REG_WENB from latched values; all read fields = 0.
  - Complete on the first cycle with REG_WWAT == 0: capture REG_WERR into M_ERR; M_RDAT = 0.
- ACCESS, read:
  - Drive REG_RADR/RTYP and REG_RENB = 1; all write fields = 0.
  - Complete on the first cycle with REG_RWAT == 0: capture REG_RDAT and REG_RERR.
- Timeout:
  - Counter clears on ACCESS entry and increments each ACCESS cycle with wait high.
  - When counter == TMO_CYC - 1 and wait is still high, abort: ERR = 1, RDAT = 0.
  - On completion or abort, go to RESP; REG_*ENB = 0 from the next cycle.
- RESP: M_ACK[g] = 1 for exactly this cycle, M_RDAT/M_ERR valid; go to IDLE.
- Outside ACCESS: all REG_* outputs = 0. Outside RESP: M_ACK = 0, M_RDAT = 0, M_ERR = 0.
- Latency: request seen in IDLE at cycle n → ACCESS n+1 → ACK at n+2 when there is no wait. Each wait cycle adds 1.
- One transaction at a time; no back-to-back bus issue. Minimum 3 cycles per access.
- Requesters drop M_REQ in the cycle after M_ACK. A requester whose M_REQ is still high in IDLE is treated as a new request.
- A request withdrawn before grant is ignored. Inputs of a granted requester are not re-sampled after IDLE.
- Reset asserted mid-ACCESS: enables drop in the next cycle, no M_ACK is issued, pointer returns to NUM_MST-1.
- M_GNT holds g from grant until the next grant.

Test Plan:
- Single read: M_REQ[0], ADR 0x10, REG_RWAT low, REG_RDAT 0xA5A5_0001 → REG_RENB high 1 cycle at n+1; M_ACK[0] at n+2; M_RDAT 0xA5A5_0001; M_ERR 0.
- Write with wait: M_REQ[1] write, WENB 0x3, WDAT 0x1234_5678, REG_WWAT high 3 cycles → REG_WENB = 0x3 for 4 cycles; M_ACK[1] at n+5; REG_WERR = 1 at completion → M_ERR = 1.
- Round robin: both M_REQ held continuously → grants 0, 1, 0, 1, ...; M_GNT matches; no requester granted twice in a row.
- Timeout: TMO_CYC = 4, REG_RWAT stuck high → REG_RENB high 4 cycles; M_ACK with M_ERR = 1 and M_RDAT = 0; next request served normally.
- Zero-enable write: WENB 0 → no REG_WENB activity; M_ACK at n+1 with M_ERR = 0.
- Reset mid-ACCESS with REG_WWAT high → all outputs 0 next cycle, no M_ACK; after release, requester 0 wins a simultaneous 0/1 request.
